// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 codes, frame length and prefix FSM states
package ps2_pkg;
  localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
  localparam logic [7:0] PS2_CODE_BRK = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
  typedef enum logic [1:0] {ST_IDLE, ST_GOT_EXT, ST_GOT_BRK, ST_GOT_EXT_BRK} ps2_state_t;
endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 lines and receives 11-bit frames with parity/stop checking and idle timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic r_clk_prev, r_fall, r_bit, r_par;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [TW-1:0] r_to;
  logic w_stop_bit, w_good, w_to_hit;
  assign w_stop_bit   = r_fall && r_cnt == 4'(PS2_FRAME_BITS - 1);
  assign w_good       = (^{r_shift, r_par}) & r_bit;
  assign w_to_hit     = !r_fall && r_cnt != 4'd0 && r_to == TO_LAST;
  assign o_byte       = r_shift;
  assign o_byte_valid = w_stop_bit & w_good;
  assign o_frame_err  = w_stop_bit & ~w_good;
  assign o_timeout    = w_to_hit;
  // synchronise both lines; the registered fall strobe and r_bit stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
      r_fall      <= 1'b0;
      r_bit       <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      r_fall      <= r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
      r_bit       <= r_data_sync[SYNC_STAGES-1];
    end
  end
  // bit counter: a high start bit is ignored, data shifts in LSB first, stop or timeout rewinds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
    end else if (r_fall) begin
      r_cnt <= w_stop_bit ? 4'd0 : (r_cnt == 4'd0 ? {3'd0, ~r_bit} : r_cnt + 4'd1);
      if (r_cnt >= 4'd1 && r_cnt <= 4'd8) r_shift <= {r_bit, r_shift[7:1]};
      if (r_cnt == 4'd9) r_par <= r_bit;
    end else if (w_to_hit) begin
      r_cnt <= 4'd0;
    end
  end
  // idle timeout runs only mid-frame; a fall in the expiry cycle wins and clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_to <= '0;
    else r_to <= (r_fall || r_cnt == 4'd0 || w_to_hit) ? '0 : r_to + TW'(1);
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 frames into {ext, scan} key events with make/break and error strobes
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] last_change,
  output logic       key_valid,
  output logic       key_down,
  output logic       frame_err
);
  logic [7:0] w_byte;
  logic w_byte_valid, w_frame_err, w_timeout;
  logic w_ext, w_brk, w_is_ext, w_is_brk, w_key;
  ps2_state_t r_state, w_next;
  ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk), .rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_byte(w_byte), .o_byte_valid(w_byte_valid), .o_frame_err(w_frame_err), .o_timeout(w_timeout)
  );
  // prefix state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  // prefixes accumulate flags, a key byte or bad frame clears them, a timeout keeps them
  always_comb begin
    w_next = r_state;
    if (w_frame_err) w_next = ST_IDLE;
    else if (w_byte_valid)
      w_next = w_is_ext ? (w_brk ? ST_GOT_EXT_BRK : ST_GOT_EXT) :
               w_is_brk ? (w_ext ? ST_GOT_EXT_BRK : ST_GOT_BRK) : ST_IDLE;
  end
  // flag decode and key-event detection
  always_comb begin
    w_ext    = r_state == ST_GOT_EXT || r_state == ST_GOT_EXT_BRK;
    w_brk    = r_state == ST_GOT_BRK || r_state == ST_GOT_EXT_BRK;
    w_is_ext = w_byte == PS2_CODE_EXT;
    w_is_brk = w_byte == PS2_CODE_BRK;
    w_key    = w_byte_valid & ~w_is_ext & ~w_is_brk;
  end
  // registered outputs: strobes every cycle, code and direction only on a key event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_change <= 9'h000;
      key_valid   <= 1'b0;
      key_down    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      key_valid <= w_key;
      frame_err <= w_frame_err | w_timeout;
      if (w_key) begin
        last_change <= {w_ext, w_byte};
        key_down    <= ~w_brk;
      end
    end
  end
endmodule
